// File: rtl/dsn_synapse_accumulator.sv
// Synapse accumulator: serially sums programmable weights of the active presynaptic inputs into a saturated 8-bit vpre pulse.
// Latency: N_INPUTS+1 cycles from the acceptance edge to the vpre_valid cycle; one event per N_INPUTS+1 cycles.
// Backpressure: ready=0 while accumulating; a spike_valid seen then is dropped and flagged on overrun the next cycle.
// Optional feature macro: DSN_SYN_INHIBIT_EN (signed inhibitory weights, result clamped to [0,255]).
module dsn_synapse_accumulator #(
  parameter int N_INPUTS = 8,
  parameter int W_WIDTH  = 8,
  parameter int AW       = $clog2(N_INPUTS)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [W_WIDTH-1:0]  wr_data,
  input  logic [N_INPUTS-1:0] spike_in,
  input  logic                spike_valid,
  output logic                ready,
  output logic [7:0]          vpre,
  output logic                vpre_valid,
  output logic                sat_flag,
  output logic                overrun
);

  // One guard bit above the worst-case sum so the accumulator never wraps.
  localparam int ACC_W = W_WIDTH + AW + 1;
  localparam logic [AW-1:0] LAST_IDX = AW'(N_INPUTS - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT} state_t;

  state_t              state;
  logic [W_WIDTH-1:0]  weights [N_INPUTS];
  logic [N_INPUTS-1:0] spikes;
  logic [AW-1:0]       idx;
  logic [ACC_W-1:0]    acc;

  logic [W_WIDTH-1:0]  cur_w;
  logic [ACC_W-1:0]    addend;
  logic [ACC_W-1:0]    acc_next;
  logic                clamp_hi;
  logic                clamp_lo;
  logic [7:0]          result;

  // Weight file: writes land at the edge, so a same-edge accumulator read still sees the old value.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < N_INPUTS; i++) begin
        weights[i] <= '0;
      end
    end else if (wr_en && (32'(wr_addr) < N_INPUTS)) begin
      weights[wr_addr] <= wr_data;
    end
  end

  // Next accumulator value for the current index and its clamped 8-bit view.
  always_comb begin
    cur_w = weights[idx];
`ifdef DSN_SYN_INHIBIT_EN
    addend = {{(AW+1){cur_w[W_WIDTH-1]}}, cur_w};
`else
    addend = {{(AW+1){1'b0}}, cur_w};
`endif
    if (!spikes[idx]) begin
      addend = '0;
    end
    acc_next = acc + addend;
`ifdef DSN_SYN_INHIBIT_EN
    clamp_lo = acc_next[ACC_W-1];
    clamp_hi = !acc_next[ACC_W-1] && (32'(acc_next) > 32'd255);
`else
    clamp_lo = 1'b0;
    clamp_hi = 32'(acc_next) > 32'd255;
`endif
    if (clamp_hi) begin
      result = 8'hFF;
    end else if (clamp_lo) begin
      result = 8'h00;
    end else begin
      result = 8'(acc_next);
    end
  end

  // Control FSM with registered outputs; the result is registered on the last accumulate edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      ready      <= 1'b1;
      vpre       <= 8'd0;
      vpre_valid <= 1'b0;
      sat_flag   <= 1'b0;
      overrun    <= 1'b0;
      spikes     <= '0;
      acc        <= '0;
      idx        <= '0;
    end else begin
      vpre       <= 8'd0;
      vpre_valid <= 1'b0;
      sat_flag   <= 1'b0;
      overrun    <= spike_valid && (state == ACCUM);
      case (state)
        IDLE, OUTPUT: begin
          if (spike_valid) begin
            spikes <= spike_in;
            acc    <= '0;
            idx    <= '0;
            state  <= ACCUM;
            ready  <= 1'b0;
          end else begin
            state  <= IDLE;
            ready  <= 1'b1;
          end
        end
        ACCUM: begin
          acc <= acc_next;
          if (idx == LAST_IDX) begin
            idx        <= '0;
            state      <= OUTPUT;
            ready      <= 1'b1;
            vpre       <= result;
            vpre_valid <= 1'b1;
            sat_flag   <= clamp_hi | clamp_lo;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dsn_synapse_accumulator.sv
// Bench for dsn_synapse_accumulator: directed scenarios with literal expectations plus randomized traffic,
// all outputs compared every cycle against an integer-level reference model.
module tb_dsn_synapse_accumulator;

  localparam int N  = 8;
  localparam int AW = 3;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [7:0]   wr_data = '0;
  logic [N-1:0] spike_in = '0;
  logic         spike_valid = 1'b0;
  logic         ready;
  logic [7:0]   vpre;
  logic         vpre_valid;
  logic         sat_flag;
  logic         overrun;

  int checks = 0;
  int errors = 0;

  dsn_synapse_accumulator #(.N_INPUTS(N), .W_WIDTH(8)) dut (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .spike_in(spike_in), .spike_valid(spike_valid), .ready(ready), .vpre(vpre),
    .vpre_valid(vpre_valid), .sat_flag(sat_flag), .overrun(overrun)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Weights as plain values; an event is a countdown of inputs still to be read.
  logic [7:0]   mw [N];
  logic [N-1:0] m_spk;
  int           m_left = 0;
  int           m_sum  = 0;
  int           m_i;
  bit           live = 0;
  int           e_vpre = 0;
  bit           e_vv = 0, e_sat = 0, e_ovr = 0, e_ready = 1;

  function automatic int wval(input logic [7:0] w);
`ifdef DSN_SYN_INHIBIT_EN
    return int'($signed(w));
`else
    return int'(w);
`endif
  endfunction

  always @(posedge clock) begin
    live = 1;
    if (reset) begin
      for (int i = 0; i < N; i++) mw[i] = 8'd0;
      m_left = 0; m_sum = 0;
      e_vv = 0; e_vpre = 0; e_sat = 0; e_ovr = 0; e_ready = 1;
    end else begin
      e_ovr = spike_valid && (m_left > 0);
      e_vv = 0; e_vpre = 0; e_sat = 0;
      if (m_left > 0) begin
        m_i = N - m_left;
        if (m_spk[m_i]) m_sum += wval(mw[m_i]);
        m_left--;
        if (m_left == 0) begin
          e_vv = 1;
          if (m_sum > 255)    begin e_vpre = 255; e_sat = 1; end
          else if (m_sum < 0) begin e_vpre = 0;   e_sat = 1; end
          else                      e_vpre = m_sum;
        end
      end else if (spike_valid) begin
        m_spk = spike_in; m_sum = 0; m_left = N;
      end
      if (wr_en && int'(wr_addr) < N) mw[wr_addr] = wr_data;
      e_ready = (m_left == 0);
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clock) begin
    if (live) begin
      chk("ready",      32'(ready),      32'(e_ready));
      chk("vpre",       32'(vpre),       32'(e_vpre));
      chk("vpre_valid", 32'(vpre_valid), 32'(e_vv));
      chk("sat_flag",   32'(sat_flag),   32'(e_sat));
      chk("overrun",    32'(overrun),    32'(e_ovr));
    end
  end

  // ---------------- directed helpers ----------------
  task automatic wr(input int a, input int d);
    logic [31:0] av, dv;
    av = a; dv = d;
    wr_en = 1'b1; wr_addr = av[AW-1:0]; wr_data = dv[7:0];
    @(negedge clock);
    wr_en = 1'b0;
  endtask

  // Runs ncyc cycles from a negedge; cycle 0 presents the event. Records result strobes and overrun.
  task automatic run_ev(input logic [7:0] spk, input int sv_a, input int sv_b,
                        input int wr_cyc, input int wr_a, input int wr_d, input int rst_cyc,
                        input int ncyc, output int first_vv, output int last_vv, output int n_vv,
                        output int vp, output int sat, output int ov_cyc);
    logic [31:0] av, dv;
    av = wr_a; dv = wr_d;
    first_vv = -1; last_vv = -1; n_vv = 0; vp = -1; sat = -1; ov_cyc = -1;
    for (int c = 0; c < ncyc; c++) begin
      if (c > 0) begin
        if (vpre_valid) begin
          if (first_vv < 0) begin first_vv = c; vp = int'(vpre); sat = int'(sat_flag); end
          last_vv = c; n_vv++;
        end
        if (overrun && ov_cyc < 0) ov_cyc = c;
      end
      spike_valid = (c == 0) || (c == sv_a) || (c == sv_b);
      spike_in    = spk;
      wr_en       = (c == wr_cyc);
      wr_addr     = av[AW-1:0];
      wr_data     = dv[7:0];
      reset       = (c == rst_cyc);
      @(negedge clock);
    end
    spike_valid = 1'b0; wr_en = 1'b0; reset = 1'b0;
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int fv, lv, nv, vp, st, oc;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_vpre_valid", 32'(vpre_valid), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // 1: w[i]=i+1, inputs 0 and 2 -> 1+3
    for (int i = 0; i < N; i++) wr(i, i + 1);
    run_ev(8'b0000_0101, -1, -1, -1, 0, 0, -1, 12, fv, lv, nv, vp, st, oc);
    chk("t1_vpre", 32'(vp), 32'd4);
    chk("t1_cycle", 32'(fv), 32'd9);
    chk("t1_sat", 32'(st), 32'd0);
    chk("t1_count", 32'(nv), 32'd1);

    // 3: drop at cycle 3, accept in OUTPUT cycle 9; inputs 0 and 7 -> 1+8
    run_ev(8'h81, 3, 9, -1, 0, 0, -1, 22, fv, lv, nv, vp, st, oc);
    chk("t3_overrun_cycle", 32'(oc), 32'd4);
    chk("t3_vpre", 32'(vp), 32'd9);
    chk("t3_first", 32'(fv), 32'd9);
    chk("t3_second", 32'(lv), 32'd18);
    chk("t3_count", 32'(nv), 32'd2);

    // 2: all weights 100 -> 800 clamps; then an empty event
    for (int i = 0; i < N; i++) wr(i, 100);
    run_ev(8'hFF, -1, -1, -1, 0, 0, -1, 12, fv, lv, nv, vp, st, oc);
    chk("t2_vpre_sat", 32'(vp), 32'd255);
    chk("t2_sat", 32'(st), 32'd1);
    run_ev(8'h00, -1, -1, -1, 0, 0, -1, 12, fv, lv, nv, vp, st, oc);
    chk("t2_zero_vpre", 32'(vp), 32'd0);
    chk("t2_zero_sat", 32'(st), 32'd0);
    chk("t2_zero_cycle", 32'(fv), 32'd9);

    // 5: weight updates racing the read of index 2 (read at the end of cycle 3)
    wr(2, 10);
    run_ev(8'b0000_0100, -1, -1, 1, 2, 50, -1, 12, fv, lv, nv, vp, st, oc);
    chk("t5_early_write", 32'(vp), 32'd50);
    wr(2, 10);
    run_ev(8'b0000_0100, -1, -1, 4, 2, 50, -1, 12, fv, lv, nv, vp, st, oc);
    chk("t5_late_write", 32'(vp), 32'd10);
    wr(2, 10);
    run_ev(8'b0000_0100, -1, -1, 3, 2, 77, -1, 12, fv, lv, nv, vp, st, oc);
    chk("t5_same_edge_write", 32'(vp), 32'd10);
    run_ev(8'b0000_0100, -1, -1, 2, 2, 33, -1, 12, fv, lv, nv, vp, st, oc);
    chk("t5_prior_edge_write", 32'(vp), 32'd33);

    // 6: 0xF6 + 5
    wr(0, 8'hF6); wr(1, 5);
    run_ev(8'b0000_0011, -1, -1, -1, 0, 0, -1, 12, fv, lv, nv, vp, st, oc);
`ifdef DSN_SYN_INHIBIT_EN
    chk("t6_vpre", 32'(vp), 32'd0);
    chk("t6_sat", 32'(st), 32'd1);
`else
    chk("t6_vpre", 32'(vp), 32'd251);
    chk("t6_sat", 32'(st), 32'd0);
`endif

    // 4: reset during cycle 4 of accumulation aborts and clears weights
    run_ev(8'hFF, -1, -1, -1, 0, 0, 4, 14, fv, lv, nv, vp, st, oc);
    chk("t4_no_result", 32'(nv), 32'd0);
    chk("t4_ready", 32'(ready), 32'd1);
    run_ev(8'hFF, -1, -1, -1, 0, 0, -1, 12, fv, lv, nv, vp, st, oc);
    chk("t4_cleared_vpre", 32'(vp), 32'd0);
    chk("t4_cleared_sat", 32'(st), 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < N; i++) wr(i, $urandom_range(0, 255));
    for (int c = 0; c < 3000; c++) begin
      spike_valid = ($urandom_range(0, 3) == 0);
      spike_in    = 8'($urandom_range(0, 255));
      wr_en       = ($urandom_range(0, 2) == 0);
      wr_addr     = 3'($urandom_range(0, N - 1));
      wr_data     = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(200, 255))
                                                : 8'($urandom_range(0, 255));
      reset       = ($urandom_range(0, 299) == 0);
      @(negedge clock);
    end
    spike_valid = 1'b0; wr_en = 1'b0; reset = 1'b0;
    repeat (12) @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
